// File: rtl/neuron_layer_seq.sv
// Sequential fully-connected learning layer: M neurons x N inputs on one MAC path.
// zero2one_t = 8-bit unsigned Q0.8, frac_t = 16-bit signed Q8.8.
// Optional macro NEURON_LAYER_SEQ_MINMAX_EN adds per-neuron activation max/min ports.
module neuron_layer_seq #(
    parameter int N          = 16,
    parameter int M          = 29,
    parameter int RATE_SHIFT = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            learn,
    input  logic [N*8-1:0]  in,
    input  logic [M*8-1:0]  expected_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [M*8-1:0]  out,
    output logic [N*8-1:0]  expected_in
`ifdef NEURON_LAYER_SEQ_MINMAX_EN
    ,
    output logic [M*16-1:0] activation_max,
    output logic [M*16-1:0] activation_min
`endif
);

    localparam int ZW = 8;
    localparam int FW = 16;
    localparam int FF = 8;
    localparam int PW = 2 * FW;
    localparam int LW = PW + $clog2(N) + 2;
    localparam int SW = ZW + $clog2(M);
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FORWARD,
        BACKWARD,
        AVERAGE,
        DONE
    } state_t;

    state_t               state_q;
    logic [MW-1:0]        m_q;
    logic [JW-1:0]        j_q;
    logic                 learn_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic signed [LW-1:0] acc_q;
    logic [ZW-1:0]        in_q    [N];
    logic [ZW-1:0]        exp_q   [M];
    logic [ZW-1:0]        out_q   [M];
    logic [ZW-1:0]        expin_q [N];
    logic [SW-1:0]        sum_q   [N];
    logic signed [FW-1:0] w_q     [M][N];

    function automatic logic [ZW-1:0] sat01(input logic signed [LW-1:0] v);
        if (v < 0) return '0;
        if (v > LW'(2 ** ZW - 1)) return '1;
        return v[ZW-1:0];
    endfunction

    function automatic logic signed [FW-1:0] satfrac(input logic signed [LW-1:0] v);
        if (v < LW'(-(2 ** (FW - 1)))) return {1'b1, {(FW - 1){1'b0}}};
        if (v > LW'(2 ** (FW - 1) - 1)) return {1'b0, {(FW - 1){1'b1}}};
        return v[FW-1:0];
    endfunction

    logic [ZW-1:0]        x_j;
    logic signed [FW-1:0] x_s;
    logic signed [FW-1:0] w_cur;
    logic signed [FW-1:0] e_s;
    logic signed [PW-1:0] p_wx;
    logic signed [PW-1:0] p_ew;
    logic signed [PW-1:0] p_ex;
    logic signed [LW-1:0] acc_d;
    logic signed [LW-1:0] c_wide;
    logic signed [LW-1:0] w_wide;
    logic [ZW-1:0]        c_d;
    logic signed [FW-1:0] w_d;
    logic                 j_last;
    logic                 m_last;

    // Both passes read the pre-update weight of the current (m, j) pair.
    always_comb begin
        x_j    = in_q[j_q];
        x_s    = signed'({{(FW - ZW){1'b0}}, x_j});
        w_cur  = w_q[m_q][j_q];
        e_s    = signed'({{(FW - ZW){1'b0}}, exp_q[m_q]})
               - signed'({{(FW - ZW){1'b0}}, out_q[m_q]});
        p_wx   = PW'(w_cur) * PW'(x_s);
        p_ew   = PW'(e_s) * PW'(w_cur);
        p_ex   = PW'(e_s) * PW'(x_s);
        acc_d  = acc_q + LW'(p_wx >>> FF);
        c_wide = LW'(x_s) + LW'(p_ew >>> FF);
        c_d    = sat01(c_wide);
        w_wide = LW'(w_cur) + (LW'(p_ex >>> FF) >>> RATE_SHIFT);
        w_d    = satfrac(w_wide);
        j_last = (j_q == JW'(N - 1));
        m_last = (m_q == MW'(M - 1));
    end

`ifdef NEURON_LAYER_SEQ_MINMAX_EN
    logic signed [FW-1:0] amax_q [M];
    logic signed [FW-1:0] amin_q [M];
    logic                 mm_init_q;
    logic signed [FW-1:0] a_raw;

    assign a_raw = satfrac(acc_d);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            j_q         <= '0;
            learn_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            for (int j = 0; j < N; j++) begin
                in_q[j]    <= '0;
                expin_q[j] <= '0;
                sum_q[j]   <= '0;
            end
            for (int m = 0; m < M; m++) begin
                exp_q[m] <= '0;
                out_q[m] <= '0;
                for (int j = 0; j < N; j++) w_q[m][j] <= '0;
            end
`ifdef NEURON_LAYER_SEQ_MINMAX_EN
            mm_init_q <= 1'b0;
            for (int m = 0; m < M; m++) begin
                amax_q[m] <= '0;
                amin_q[m] <= '0;
            end
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < N; j++) in_q[j] <= in[j*ZW +: ZW];
                        for (int m = 0; m < M; m++) exp_q[m] <= expected_out[m*ZW +: ZW];
                        learn_q    <= learn;
                        acc_q      <= '0;
                        m_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (j_last) begin
                        out_q[m_q] <= sat01(acc_d);
                        acc_q      <= '0;
                        j_q        <= '0;
`ifdef NEURON_LAYER_SEQ_MINMAX_EN
                        if (!mm_init_q || a_raw > amax_q[m_q]) amax_q[m_q] <= a_raw;
                        if (!mm_init_q || a_raw < amin_q[m_q]) amin_q[m_q] <= a_raw;
                        if (m_last) mm_init_q <= 1'b1;
`endif
                        if (m_last) begin
                            m_q <= '0;
                            if (learn_q) begin
                                for (int j = 0; j < N; j++) sum_q[j] <= '0;
                                state_q <= BACKWARD;
                            end else begin
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                        end else begin
                            m_q <= m_q + MW'(1);
                        end
                    end else begin
                        acc_q <= acc_d;
                        j_q   <= j_q + JW'(1);
                    end
                end
                BACKWARD: begin
                    sum_q[j_q]     <= sum_q[j_q] + SW'(c_d);
                    w_q[m_q][j_q]  <= w_d;
                    if (j_last) begin
                        j_q <= '0;
                        if (m_last) begin
                            m_q     <= '0;
                            state_q <= AVERAGE;
                        end else begin
                            m_q <= m_q + MW'(1);
                        end
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                AVERAGE: begin
                    expin_q[j_q] <= ZW'(sum_q[j_q] / SW'(M));
                    if (j_last) begin
                        j_q         <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        j_q <= j_q + JW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    for (genvar gm = 0; gm < M; gm++) begin : g_out
        assign out[gm*ZW +: ZW] = out_q[gm];
`ifdef NEURON_LAYER_SEQ_MINMAX_EN
        assign activation_max[gm*FW +: FW] = amax_q[gm];
        assign activation_min[gm*FW +: FW] = amin_q[gm];
`endif
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_expin
        assign expected_in[gj*ZW +: ZW] = expin_q[gj];
    end

endmodule

// File: doc/neuron_layer_seq.md
# neuron_layer_seq

Time-multiplexed, parametrised fully-connected learning layer: M neurons over N inputs share a single multiply-accumulate datapath instead of one `neuron_learn` instance per neuron. It holds an internal weight array and runs a forward pass with an optional error-driven weight update and backward pass. The layer averages the expected inputs it produces for the upstream layer. It sits between layers on a valid/ready handshake and generalises the fixed-width instantiated layers, which have no sequencing.

## Interface

Parameters:
- `N`, 16: inputs per neuron.
- `M`, 29: neuron count; at least 1.
- `RATE_SHIFT`, 3: learning rate is 2^-RATE_SHIFT.

Ports:
- `clock`, in, 1: sole clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: request carries a sample.
- `in_ready`, out, 1: layer can accept a sample; high only in IDLE.
- `learn`, in, 1: sampled at accept; 1 selects a learning pass.
- `in`, in, zero2one_t [N-1:0]: input sample; sampled at accept.
- `expected_out`, in, zero2one_t [M-1:0]: targets; sampled at accept.
- `out_valid`, out, 1: result available; high only in DONE.
- `out_ready`, in, 1: consumer takes the result.
- `out`, out, zero2one_t [M-1:0]: neuron activations.
- `expected_in`, out, zero2one_t [N-1:0]: averaged expected inputs for the upstream layer.
- `activation_max`, out, frac_t [M-1:0]: present only under the macro.
- `activation_min`, out, frac_t [M-1:0]: present only under the macro.

## Operation

- **States:** IDLE, FORWARD, BACKWARD, AVERAGE, DONE.
- **IDLE:** on `in_valid && in_ready`, capture `in`, `expected_out` and `learn`; clear the accumulator and indices m=0, j=0; go to FORWARD.
- **FORWARD:** one (m, j) pair per cycle, j innermost.
  - acc += w[m][j] * in[j], using frac_t multiply; the product keeps the frac_t fractional bits with arithmetic truncation.
  - At j = N-1, write `out[m]` = the full sum saturated to the zero2one_t range [0, max], then clear acc.
  - After (M-1, N-1): go to BACKWARD if learn=1, else DONE.
- **BACKWARD:** one (m, j) pair per cycle.
  - e = expected_out[m] - out[m], signed frac_t.
  - c = sat01(in[j] + e * w_old[m][j]); add c into sum[j].
  - sum[j] is zero2one_t width + clog2(M) bits, cleared on entry to BACKWARD.
  - w[m][j] = satfrac(w_old + ((e * in[j]) >>> RATE_SHIFT)).
  - Reads use the pre-update weight in the same cycle.
  - After (M-1, N-1), go to AVERAGE.
- **AVERAGE:** one j per cycle; `expected_in[j]` = sum[j] / M (unsigned, truncating). After j = N-1, go to DONE.
- **DONE:** `out_valid` = 1. On `out_ready`, go to IDLE.
- `out` and `expected_in` hold between passes. `expected_in` is unchanged by a learn=0 pass.
- `in_valid` outside IDLE is ignored; inputs are not re-sampled mid-pass.

## Timing

- **Reset values:** state IDLE; all weights, `out`, `expected_in` and sums are 0; `in_ready` = 1; `out_valid` = 0; `activation_max` and `activation_min` are 0.
- **Latency:** `out_valid` rises exactly M·N edges after the accepting edge when learn=0, or 2·M·N + N edges when learn=1.
- **Back-to-back:** DONE with `out_ready` returns to IDLE at the next edge. A new accept is possible one cycle later; there is no same-cycle DONE-to-accept.
- **Backpressure:** `out_ready` low holds DONE and all outputs indefinitely.
- **Reset mid-pass:** immediate return to IDLE with all reset values, including weights.
- **Index wrap:** j wraps from N-1 to 0 and increments m. m never exceeds M-1.
- `learn` toggling mid-pass has no effect.

## Configuration

- **Macro:** `NEURON_LAYER_SEQ_MINMAX_EN`.
- **Defined:** `activation_max` and `activation_min` ports exist.
  - At each neuron's j = N-1 in FORWARD, the raw unsaturated sum (frac_t-saturated) updates the running max and min for that neuron.
  - The first pass after reset loads both values directly.
- **Undefined:** the ports and their registers are absent; all other behaviour is identical.

## Test plan

Benches use N=2, M=3, RATE_SHIFT=1.

- **Reset:** assert `reset` mid-idle -> `in_ready`=1, `out_valid`=0, `out`={0,0,0}, `expected_in`={0,0}.
- **Inference after reset:** `in`={0.5,0.5}, learn=0 -> `out_valid` exactly 6 edges after accept; `out`={0,0,0}.
- **Learning pass:** `in`={0.5,0.25}, `expected_out` all 0.5, learn=1.
  - `out_valid` after 14 edges; `expected_in`={0.5,0.25}.
  - Weights become w[m][0]=0.125 and w[m][1]=0.0625.
  - A following learn=0 pass with the same `in` -> `out`[m]=0.078125.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE while pulsing `in_valid` -> `out_valid` stays 1, `in_ready` stays 0, outputs stable, no second accept.
- **Reset mid-BACKWARD:** -> `in_ready`=1 within the reset assertion; the next inference gives `out`={0,0,0}.
- **Saturation and macro:** repeat learning with `in`={1-lsb, 1-lsb} and `expected_out` at max.
  - `out`[m] clamps at the zero2one_t max with no wrap.
  - Under `NEURON_LAYER_SEQ_MINMAX_EN`, `activation_max` is non-decreasing across passes.
